// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the fifo write-side arbiter.
// The defaults also serve any future read-side schedulers.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_MAX = 4;
    localparam int ID_W          = $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward
// from last_ptr+1, wrapping modulo NUM_REQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0] idx;
    logic          found;

    always_comb begin
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = '0;
        // Wide sum avoids modulo; one conditional subtract wraps it.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last_ptr} + SW'(k);
            if (idx >= SW'(NUM_REQ))
                idx = idx - SW'(NUM_REQ);
            if (!found && req[idx[IDX_W-1:0]]) begin
                winner = idx[IDX_W-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one fifo_sync write port
// among NUM_REQ valid/ready producers; writes are gated on fifo_full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_wdata,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_id
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

    arb_state_t        state, state_nx;
    logic [IDX_W-1:0]  last_ptr, winner;
    logic [CNT_W-1:0]  beat_cnt;
    logic              any_req, beat, rel;
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (req_valid),
        .last_ptr (last_ptr),
        .winner   (winner),
        .any_req  (any_req)
    );

    always_comb begin
        state_nx    = state;
        req_ready   = '0;
        fifo_wr     = 1'b0;
        fifo_wdata  = '0;
        grant_valid = 1'b0;
        beat        = 1'b0;
        rel         = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nx = GRANT;
            end
            GRANT: begin
                beat = req_valid[grant_id] & ~fifo_full;
                // A bubble ends the burst; a full stall never does.
                rel  = ~req_valid[grant_id] | (beat & (beat_cnt == LAST_BEAT));
                if (rel)
                    state_nx = IDLE;
                // Reset cycle must not leak a write to the FIFO.
                if (!rst) begin
                    grant_valid         = 1'b1;
                    req_ready[grant_id] = ~fifo_full;
                    fifo_wr             = beat;
                    fifo_wdata          = data_arr[grant_id];
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            grant_id <= '0;
            last_ptr <= IDX_W'(NUM_REQ - 1);
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                grant_id <= winner;
                beat_cnt <= '0;
            end
            if (beat)
                beat_cnt <= beat_cnt + 1'b1;
            if (rel)
                last_ptr <= grant_id;
        end
    end

endmodule
